// File: rtl/score_pkg.sv
// Shared types for the hexagon-game score keeper: game state encoding and BCD score type.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [15:0] bcd4_t;

  localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One decimal digit of a ripple BCD counter; carry_out is combinational so a
// whole chain of digits rolls over in a single cycle.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_in,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc_in) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Frame-synchronous score / game-over tracker for the hexagon game.
// Optional high-score register enabled by defining SCORE_KEEPER_HISCORE_EN.
module score_keeper
  import score_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SCORE_MAX        = 8191
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        VGA_VS,
  input  logic        start,
  input  logic        is_collision,
  input  logic        kb_reset,
  output logic        frame_tick,
  output logic [12:0] Score,
  output bcd4_t       Score_BCD,
  output logic        game_over,
  output logic        running,
  output bcd4_t       Hi_Score_BCD
);

  localparam int PW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;

  state_t            state, state_nxt;
  logic              vs_meta, vs_sync, vs_sync_d;
  logic [PW-1:0]     presc;
  logic              presc_wrap;
  logic              score_inc;
  logic              score_clr;
  logic [BCD_DIGITS:0] carry;

  // VS idles high, so the synchronizer resets to 1 to avoid a false edge at release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta    <= 1'b1;
      vs_sync    <= 1'b1;
      vs_sync_d  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= VGA_VS;
      vs_sync    <= vs_meta;
      vs_sync_d  <= vs_sync;
      frame_tick <= vs_sync_d && !vs_sync;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (kb_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (is_collision) state_nxt = OVER;
        OVER:    state_nxt = OVER;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign presc_wrap = (presc == PW'(FRAMES_PER_POINT - 1));
  assign score_clr  = kb_reset || (state == IDLE);
  assign score_inc  = (state == RUN) && frame_tick && presc_wrap && !is_collision
                      && !kb_reset && (Score != 13'(SCORE_MAX));
  assign running    = (state == RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      presc     <= '0;
      Score     <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      game_over <= (state == RUN) && is_collision && !kb_reset;
      if (score_clr) begin
        presc <= '0;
        Score <= '0;
      end else begin
        if ((state == RUN) && frame_tick && !is_collision)
          presc <= presc_wrap ? '0 : presc + PW'(1);
        if (score_inc)
          Score <= Score + 13'd1;
      end
    end
  end

  // Decimal mirror of Score, advanced by the same increment so the two never diverge.
  assign carry[0] = score_inc;
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .inc_in    (carry[i]),
      .clr       (score_clr),
      .digit     (Score_BCD[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  bcd4_t hi_q;

  // Packed BCD compares correctly as a plain unsigned number, thousands digit first.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_q <= '0;
    end else if ((state == RUN) && (state_nxt == OVER) && (Score_BCD > hi_q)) begin
      hi_q <= Score_BCD;
    end
  end

  assign Hi_Score_BCD = hi_q;
`else
  assign Hi_Score_BCD = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: timing of frame_tick, scoring, BCD carries,
// collision/reset priority, saturation and the optional high score.
module tb_score_keeper;
  import score_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vs, start, coll, kb;
  logic        frame_tick, game_over, running;
  logic [12:0] score;
  bcd4_t       score_bcd, hi_bcd;

  logic        f_vs, f_start, f_coll, f_kb;
  logic        f_tick, f_over, f_running;
  logic [12:0] f_score;
  bcd4_t       f_bcd, f_hi;

  int total = 0;
  int bad   = 0;
  int tick_cnt = 0;

`ifdef SCORE_KEEPER_HISCORE_EN
  localparam bcd4_t HI_EXP = 16'h0042;
`else
  localparam bcd4_t HI_EXP = 16'h0000;
`endif

  always #5 Clk = ~Clk;

  score_keeper #(.FRAMES_PER_POINT(6), .SCORE_MAX(8191)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_VS(vs), .start(start),
    .is_collision(coll), .kb_reset(kb), .frame_tick(frame_tick),
    .Score(score), .Score_BCD(score_bcd), .game_over(game_over),
    .running(running), .Hi_Score_BCD(hi_bcd)
  );

  // Second instance at one frame per point so long counts fit in a short run.
  score_keeper #(.FRAMES_PER_POINT(1), .SCORE_MAX(8191)) dut_fast (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_VS(f_vs), .start(f_start),
    .is_collision(f_coll), .kb_reset(f_kb), .frame_tick(f_tick),
    .Score(f_score), .Score_BCD(f_bcd), .game_over(f_over),
    .running(f_running), .Hi_Score_BCD(f_hi)
  );

  always @(negedge Clk) if (frame_tick === 1'b1) tick_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // One VS low pulse on the main DUT; checks the 3-edge tick latency and 1-cycle width.
  task automatic frame();
    vs = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("tick_latency", {31'd0, frame_tick}, {31'd0, k == 3});
    end
    vs = 1'b1;
    cyc();
    check("tick_width", {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic fast_frames(input int n);
    for (int i = 0; i < n; i++) begin
      f_vs = 1'b0; cyc();
      f_vs = 1'b1; cyc();
    end
    repeat (3) cyc();
  endtask

  initial begin
    Reset_n = 1'b0;
    vs = 1'b1; start = 1'b0; coll = 1'b0; kb = 1'b0;
    f_vs = 1'b1; f_start = 1'b0; f_coll = 1'b0; f_kb = 1'b0;
    #1;
    check("rst_score", {19'd0, score}, 32'd0);
    repeat (3) cyc();
    Reset_n = 1'b1;
    repeat (4) cyc();
    check("idle_score", {19'd0, score}, 32'd0);
    check("idle_bcd", {16'd0, score_bcd}, 32'd0);
    check("idle_running", {31'd0, running}, 32'd0);
    check("idle_tick", {31'd0, frame_tick}, 32'd0);
    check("idle_over", {31'd0, game_over}, 32'd0);
    check("idle_hi", {16'd0, hi_bcd}, 32'd0);

    // Game 1: 60 frames at 6 frames/point gives 10 points.
    start = 1'b1;
    cyc();
    check("run_running", {31'd0, running}, 32'd1);
    tick_cnt = 0;
    frames(54);
    check("score_9", {19'd0, score}, 32'd9);
    check("bcd_9", {16'd0, score_bcd}, 32'h0009);
    frames(6);
    check("score_10", {19'd0, score}, 32'd10);
    check("bcd_10", {16'd0, score_bcd}, 32'h0010);
    check("tick_count", tick_cnt, 32'd60);

    // Up to 42, then line a collision up with the scoring tick.
    frames(192);
    check("score_42", {19'd0, score}, 32'd42);
    frames(5);
    check("score_42_pre", {19'd0, score}, 32'd42);
    vs = 1'b0;
    repeat (3) cyc();
    check("tick_at_coll", {31'd0, frame_tick}, 32'd1);
    coll = 1'b1;
    vs = 1'b1;
    cyc();
    coll = 1'b0;
    check("coll_over", {31'd0, game_over}, 32'd1);
    check("coll_score", {19'd0, score}, 32'd42);
    check("coll_bcd", {16'd0, score_bcd}, 32'h0042);
    check("coll_running", {31'd0, running}, 32'd0);
    check("coll_hi", {16'd0, hi_bcd}, {16'd0, HI_EXP});
    cyc();
    check("over_pulse_end", {31'd0, game_over}, 32'd0);
    frames(12);
    check("over_frozen", {19'd0, score}, 32'd42);

    // Game 2: lower score must not replace the high score.
    kb = 1'b1;
    cyc();
    check("kb_score", {19'd0, score}, 32'd0);
    check("kb_bcd", {16'd0, score_bcd}, 32'd0);
    check("kb_running", {31'd0, running}, 32'd0);
    check("kb_hi", {16'd0, hi_bcd}, {16'd0, HI_EXP});
    kb = 1'b0;
    cyc();
    check("rerun_running", {31'd0, running}, 32'd1);
    frames(102);
    check("score_17", {19'd0, score}, 32'd17);
    coll = 1'b1;
    cyc();
    coll = 1'b0;
    check("g2_over", {31'd0, game_over}, 32'd1);
    check("g2_bcd", {16'd0, score_bcd}, 32'h0017);
    check("g2_hi", {16'd0, hi_bcd}, {16'd0, HI_EXP});

    // Fast instance: 999 -> 1000 carry and saturation at 8191.
    f_start = 1'b1;
    cyc();
    fast_frames(999);
    check("f_score_999", {19'd0, f_score}, 32'd999);
    check("f_bcd_999", {16'd0, f_bcd}, 32'h0999);
    fast_frames(1);
    check("f_score_1000", {19'd0, f_score}, 32'd1000);
    check("f_bcd_1000", {16'd0, f_bcd}, 32'h1000);
    fast_frames(8191 - 1000 + 20);
    check("f_sat_score", {19'd0, f_score}, 32'd8191);
    check("f_sat_bcd", {16'd0, f_bcd}, 32'h8191);
    check("f_sat_running", {31'd0, f_running}, 32'd1);
    f_kb = 1'b1; f_coll = 1'b1; f_start = 1'b0;
    cyc();
    f_kb = 1'b0; f_coll = 1'b0;
    check("f_kbcoll_over", {31'd0, f_over}, 32'd0);
    check("f_kbcoll_running", {31'd0, f_running}, 32'd0);
    check("f_kbcoll_score", {19'd0, f_score}, 32'd0);
    check("f_kbcoll_bcd", {16'd0, f_bcd}, 32'd0);
    cyc();
    check("f_kbcoll_over2", {31'd0, f_over}, 32'd0);

    // Async reset in the middle of a run clears everything at once.
    kb = 1'b1;
    cyc();
    kb = 1'b0;
    cyc();
    frames(12);
    check("pre_rst_score", {19'd0, score}, 32'd2);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_score", {19'd0, score}, 32'd0);
    check("async_bcd", {16'd0, score_bcd}, 32'd0);
    check("async_running", {31'd0, running}, 32'd0);
    check("async_hi", {16'd0, hi_bcd}, 32'd0);
    cyc();
    Reset_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Frame-synchronous score and game-over tracker for the hexagon game. It counts survived frames while the game is in play and converts them to points. It freezes on the first wall/player collision and clears on keyboard reset. It drives the binary score and a ready-made 4-digit BCD score straight to the hex display drivers, replacing the combinational binary-to-BCD path.

## Interface
Parameters:
- FRAMES_PER_POINT, 6: vertical frames per score increment (10 points/s at 60 Hz).
- SCORE_MAX, 8191: saturation value of the score; must be ≤ 8191.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Reset_n  input  1  asynchronous, active-low reset.
- VGA_VS  input  1  VGA vertical sync, active low; asynchronous to Clk.
- start  input  1  level; game has left the menu and is playing.
- is_collision  input  1  level; wall and player pixels overlap this cycle.
- kb_reset  input  1  level; Enter key held.
- frame_tick  output  1  one-cycle pulse per VS falling edge.
- Score  output  13  binary score.
- Score_BCD  output  16  score as four BCD digits, thousands in [15:12].
- game_over  output  1  one-cycle pulse on entry to OVER.
- running  output  1  high while in RUN.
- Hi_Score_BCD  output  16  best score of this power-up, BCD.

## Operation
- **VS sync:** two-flop synchronizer, then a registered edge detector. frame_tick fires on the sampled 1→0 transition of VGA_VS.
- **FSM states** (two-bit encoding, IDLE=0): IDLE, RUN, OVER.
  - IDLE: Score, Score_BCD and the prescaler are held at 0. Goes to RUN when start=1 and kb_reset=0.
  - RUN: running=1. Each frame_tick advances the prescaler 0..FRAMES_PER_POINT-1. On wrap, Score increments and Score_BCD increments in the same cycle.
  - RUN→OVER on any cycle with is_collision=1. game_over pulses for one cycle. Score freezes.
  - OVER: holds Score. Goes to IDLE on kb_reset=1.
- kb_reset=1 forces IDLE from any state. It clears Score, Score_BCD and the prescaler. It does not clear the high score.
- Same-cycle events in RUN:
  - kb_reset beats is_collision: go to IDLE, no game_over.
  - is_collision beats a scoring tick: no increment.
- **Saturation:** at Score=SCORE_MAX further ticks do not increment. Score_BCD stays consistent with Score.
- **BCD counter:** per-digit ripple. A digit at 9 rolls to 0 and carries into the next digit, all in one cycle. Score_BCD always equals the BCD encoding of Score.
- **Reset values:** all outputs 0, state IDLE, prescaler 0, synchronizer flops 1 (idle VS level).

## Timing
- VS falling edge to frame_tick: 3 Clk edges (2 sync + 1 edge register).
- frame_tick to Score/Score_BCD update: 1 cycle (registered).
- is_collision to game_over and state=OVER: 1 cycle. Score sampled in that cycle is final.
- kb_reset to cleared outputs: 1 cycle.
- Asynchronous Reset_n assertion mid-RUN clears everything immediately, including Hi_Score_BCD. Release is synchronous to the design's reset synchronizer upstream.

## Configuration
- Macro: SCORE_KEEPER_HISCORE_EN.
- **Defined:** a 16-bit BCD high-score register updates on the RUN→OVER transition when Score_BCD > Hi_Score_BCD (digit-wise unsigned compare from thousands down). It is cleared only by Reset_n.
- **Undefined:** the register and comparator are not built. Hi_Score_BCD is tied to 0.

## Structure
- **Package score_pkg:** the state enum (IDLE, RUN, OVER); typedef bcd4_t (logic [15:0]); constant BCD_DIGITS=4.
- **Sub-module bcd_digit_cnt:** one decimal digit with inc_in, clr and carry_out. Instantiate it four times, chained through carry_out.
- Synchronizer, prescaler, FSM and high-score register live in the top module.

## Test plan
- Reset_n low, then high with VGA_VS=1 → all outputs 0, running=0, no frame_tick.
- start=1, then 60 VS falling edges at FRAMES_PER_POINT=6 → Score=10, Score_BCD=16'h0010, frame_tick count=60, each pulse 3 cycles after its edge.
- Preload to Score=9 and deliver one scoring tick → Score=10, Score_BCD=16'h0010. From 999 → 16'h1000.
- is_collision and a scoring tick in the same cycle at Score=42 → game_over pulse, Score stays 42, later ticks ignored.
- OVER at 42, kb_reset, play to 17 and collide → with the macro Hi_Score_BCD=16'h0042 throughout; without the macro, 0.
- Drive ticks past 8191 → Score holds 8191, Score_BCD=16'h8191. kb_reset and is_collision together in RUN → IDLE, no game_over.
